uart8: RTL and testbench

//  Full-duplex 8N1 UART: one transmitter and one receiver sharing a clock and reset.

---
 rtl/uart8.sv | 239 +++++++++++++++++++++++
 tb/tb_uart8.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart8.sv
// uart8: full-duplex 8N1 UART (1 start bit, 8 data bits LSB first, 1 stop bit, line idles high).
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset
//   rx_en_i      receiver enable; low forces RX to idle
//   rx_in_i      serial input (asynchronous, synchronised internally)
//   rx_busy_o    high while a confirmed frame is being received
//   rx_done_o    one-clk pulse: new byte on rx_out_o
//   rx_err_o     one-clk pulse: stop bit sampled low
//   rx_out_o     last good received byte
//   tx_en_i      transmitter enable; low forces TX to idle and tx_out_o high
//   tx_start_i   level request; frames are sent back-to-back while high
//   tx_in_i      byte to send, latched when a frame starts
//   tx_busy_o    high from start bit through stop bit
//   tx_done_o    one-clk pulse after the stop bit
//   tx_out_o     serial output
module uart8 #(
  parameter int unsigned CLOCK_RATE = 12000000,
  parameter int unsigned BAUD_RATE  = 9600
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_en_i,
  input  logic       rx_in_i,
  output logic       rx_busy_o,
  output logic       rx_done_o,
  output logic       rx_err_o,
  output logic [7:0] rx_out_o,
  input  logic       tx_en_i,
  input  logic       tx_start_i,
  input  logic [7:0] tx_in_i,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic       tx_out_o
);

  localparam int unsigned TxDiv  = CLOCK_RATE / BAUD_RATE;
  localparam int unsigned RxDiv  = CLOCK_RATE / (16 * BAUD_RATE);
  localparam int unsigned TxCntW = $clog2(TxDiv + 1);
  localparam int unsigned RxCntW = $clog2(RxDiv + 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // ---------------- Transmitter ----------------
  state_e              tx_state_q, tx_state_d;
  logic [TxCntW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [7:0]          tx_shift_q, tx_shift_d;
  logic [2:0]          tx_bit_q, tx_bit_d;
  logic                tx_done_q, tx_done_d;
  logic                tx_tick;

  assign tx_tick = (tx_cnt_q == TxCntW'(TxDiv - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_done_q  <= tx_done_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_done_d  = 1'b0;
    tx_cnt_d   = tx_tick ? '0 : tx_cnt_q + 1'b1;
    if (!tx_en_i) begin
      tx_state_d = StIdle;
      tx_cnt_d   = '0;
    end else begin
      unique case (tx_state_q)
        StIdle: begin
          if (tx_start_i) begin
            tx_state_d = StStart;
            tx_shift_d = tx_in_i;
            tx_cnt_d   = '0;  // start bit gets a full bit time
          end
        end
        StStart: begin
          if (tx_tick) begin
            tx_state_d = StData;
            tx_bit_d   = '0;
          end
        end
        StData: begin
          if (tx_tick) begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 1'b1;
            if (tx_bit_q == 3'd7) tx_state_d = StStop;
          end
        end
        StStop: begin
          if (tx_tick) begin
            tx_done_d = 1'b1;
            // Held request chains straight into the next start bit.
            if (tx_start_i) begin
              tx_state_d = StStart;
              tx_shift_d = tx_in_i;
            end else begin
              tx_state_d = StIdle;
            end
          end
        end
        default: tx_state_d = StIdle;
      endcase
    end
  end

  // Gated by tx_en_i so an abort drives the line high in the same cycle.
  always_comb begin
    tx_out_o = 1'b1;
    if (tx_en_i) begin
      case (tx_state_q)
        StStart: tx_out_o = 1'b0;
        StData:  tx_out_o = tx_shift_q[0];
        default: tx_out_o = 1'b1;
      endcase
    end
  end

  assign tx_busy_o = tx_en_i && (tx_state_q != StIdle);
  assign tx_done_o = tx_en_i && tx_done_q;

  // ---------------- Receiver ----------------
  state_e              rx_state_q, rx_state_d;
  logic [1:0]          rx_sync_q;
  logic [RxCntW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [3:0]          rx_os_q, rx_os_d;
  logic [2:0]          rx_bit_q, rx_bit_d;
  logic [7:0]          rx_shift_q, rx_shift_d;
  logic [7:0]          rx_out_q, rx_out_d;
  logic                rx_done_q, rx_done_d;
  logic                rx_err_q, rx_err_d;
  logic                rx_tick;
  logic                rx_line;

  assign rx_tick = (rx_cnt_q == RxCntW'(RxDiv - 1));
  assign rx_line = rx_sync_q[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_state_q <= StIdle;
      rx_sync_q  <= 2'b11;
      rx_cnt_q   <= '0;
      rx_os_q    <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_out_q   <= '0;
      rx_done_q  <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_sync_q  <= {rx_sync_q[0], rx_in_i};
      rx_cnt_q   <= rx_cnt_d;
      rx_os_q    <= rx_os_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_out_q   <= rx_out_d;
      rx_done_q  <= rx_done_d;
      rx_err_q   <= rx_err_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_os_d    = rx_os_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_out_d   = rx_out_q;
    rx_done_d  = 1'b0;
    rx_err_d   = 1'b0;
    rx_cnt_d   = rx_tick ? '0 : rx_cnt_q + 1'b1;
    if (!rx_en_i) begin
      rx_state_d = StIdle;
      rx_cnt_d   = '0;
    end else begin
      unique case (rx_state_q)
        StIdle: begin
          if (!rx_line) begin
            rx_state_d = StStart;
            rx_os_d    = '0;
          end
        end
        StStart: begin
          if (rx_tick) begin
            rx_os_d = rx_os_q + 1'b1;
            // Half a bit in: still low means a real start bit, else a glitch.
            if (rx_os_q == 4'd7) begin
              rx_os_d    = '0;
              rx_bit_d   = '0;
              rx_state_d = rx_line ? StIdle : StData;
            end
          end
        end
        StData: begin
          if (rx_tick) begin
            rx_os_d = rx_os_q + 1'b1;  // wraps 15 -> 0 at each bit centre
            if (rx_os_q == 4'd15) begin
              rx_shift_d = {rx_line, rx_shift_q[7:1]};
              rx_bit_d   = rx_bit_q + 1'b1;
              if (rx_bit_q == 3'd7) rx_state_d = StStop;
            end
          end
        end
        StStop: begin
          if (rx_tick) begin
            rx_os_d = rx_os_q + 1'b1;
            if (rx_os_q == 4'd15) begin
              rx_state_d = StIdle;
              if (rx_line) begin
                rx_out_d  = rx_shift_q;
                rx_done_d = 1'b1;
              end else begin
                rx_err_d = 1'b1;
              end
            end
          end
        end
        default: rx_state_d = StIdle;
      endcase
    end
  end

  assign rx_busy_o = rx_en_i && ((rx_state_q == StData) || (rx_state_q == StStop));
  assign rx_done_o = rx_en_i && rx_done_q;
  assign rx_err_o  = rx_en_i && rx_err_q;
  assign rx_out_o  = rx_out_q;

endmodule

// File: tb/tb_uart8.sv
// Two uart8 instances: u_a transmits into u_b; u_b's receive line can be switched to a
// bench-driven line for framing-error and glitch stimulus.
module tb_uart8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_tx_en, a_tx_start;
  logic [7:0] a_tx_in;
  logic       a_tx_busy, a_tx_done, a_tx_out;
  logic       a_rx_busy, a_rx_done, a_rx_err;
  logic [7:0] a_rx_out;

  logic       b_rx_en, b_rx_in;
  logic       b_rx_busy, b_rx_done, b_rx_err;
  logic [7:0] b_rx_out;
  logic       b_tx_busy, b_tx_done, b_tx_out;

  logic line_sel, tb_line;
  assign b_rx_in = line_sel ? tb_line : a_tx_out;

  uart8 u_a (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_en_i    (1'b1),
    .rx_in_i    (b_tx_out),
    .rx_busy_o  (a_rx_busy),
    .rx_done_o  (a_rx_done),
    .rx_err_o   (a_rx_err),
    .rx_out_o   (a_rx_out),
    .tx_en_i    (a_tx_en),
    .tx_start_i (a_tx_start),
    .tx_in_i    (a_tx_in),
    .tx_busy_o  (a_tx_busy),
    .tx_done_o  (a_tx_done),
    .tx_out_o   (a_tx_out)
  );

  uart8 u_b (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_en_i    (b_rx_en),
    .rx_in_i    (b_rx_in),
    .rx_busy_o  (b_rx_busy),
    .rx_done_o  (b_rx_done),
    .rx_err_o   (b_rx_err),
    .rx_out_o   (b_rx_out),
    .tx_en_i    (1'b1),
    .tx_start_i (1'b0),
    .tx_in_i    (8'h00),
    .tx_busy_o  (b_tx_busy),
    .tx_done_o  (b_tx_done),
    .tx_out_o   (b_tx_out)
  );

  int cmp_cnt = 0;
  int mis_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Event monitor, sampled on the falling edge.
  int         cyc = 0;
  int         rx_done_cnt = 0;
  int         rx_err_cnt = 0;
  int         busy_cnt = 0;
  int         tx_done_cnt = 0;
  logic [7:0] rx_bytes [0:7];
  int         rx_done_cyc [0:7];
  int         tx_done_cyc [0:7];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (b_rx_done) begin
        rx_bytes[rx_done_cnt % 8]    <= b_rx_out;
        rx_done_cyc[rx_done_cnt % 8] <= cyc;
        rx_done_cnt                  <= rx_done_cnt + 1;
      end
      if (b_rx_err)  rx_err_cnt <= rx_err_cnt + 1;
      if (b_rx_busy) busy_cnt <= busy_cnt + 1;
      if (a_tx_done) begin
        tx_done_cyc[tx_done_cnt % 8] <= cyc;
        tx_done_cnt                  <= tx_done_cnt + 1;
      end
    end
  end

  // Drives one frame on tb_line; the stop bit is held low for stop_low clocks.
  task automatic drive_bad_frame(input logic [7:0] data, input int stop_low);
    tb_line = 1'b0;
    repeat (1250) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tb_line = data[i];
      repeat (1250) @(negedge clk);
    end
    tb_line = 1'b0;
    repeat (stop_low) @(negedge clk);
    tb_line = 1'b1;
  endtask

  int t0, lat, d0, e0, b0, td0;

  initial begin
    rst        = 1'b1;
    a_tx_en    = 1'b1;
    a_tx_start = 1'b0;
    a_tx_in    = 8'h00;
    b_rx_en    = 1'b1;
    line_sel   = 1'b0;
    tb_line    = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx_out", a_tx_out, 1);
    check_eq("rst_tx_busy", a_tx_busy, 0);
    check_eq("rst_tx_done", a_tx_done, 0);
    check_eq("rst_rx_out", b_rx_out, 0);
    check_eq("rst_rx_busy", b_rx_busy, 0);
    check_eq("rst_rx_done", b_rx_done, 0);
    check_eq("rst_rx_err", b_rx_err, 0);

    @(negedge clk) rst = 1'b0;
    repeat (100) @(negedge clk);

    // Frame 1: 0x7A with start held; switch tx_in mid-frame for frame 2.
    a_tx_in    = 8'h7A;
    a_tx_start = 1'b1;
    t0         = cyc;
    repeat (3000) @(negedge clk);
    check_eq("tx_busy_mid", a_tx_busy, 1);
    a_tx_in = 8'hB1;
    for (int i = 0; i < 12000 && rx_done_cnt < 1; i++) @(negedge clk);
    @(negedge clk);
    check_eq("rx1_seen", rx_done_cnt, 1);
    check_eq("rx1_byte", rx_bytes[0], 8'h7A);
    lat = rx_done_cyc[0] - t0;
    check_eq("rx1_latency_ok", (lat >= 11700 && lat <= 12000), 1);
    check_eq("rx1_no_err", rx_err_cnt, 0);

    for (int i = 0; i < 2000 && tx_done_cnt < 1; i++) @(negedge clk);
    check_eq("tx1_done", tx_done_cnt, 1);
    repeat (2000) @(negedge clk);
    a_tx_start = 1'b0;  // drop request during frame 2
    for (int i = 0; i < 14000 && rx_done_cnt < 2; i++) @(negedge clk);
    @(negedge clk);
    check_eq("rx2_seen", rx_done_cnt, 2);
    check_eq("rx2_byte", rx_bytes[1], 8'hB1);
    for (int i = 0; i < 3000 && tx_done_cnt < 2; i++) @(negedge clk);
    @(negedge clk);
    check_eq("tx2_done", tx_done_cnt, 2);
    check_eq("b2b_period", tx_done_cyc[1] - tx_done_cyc[0], 12500);
    repeat (1500) @(negedge clk);
    check_eq("idle_tx_out", a_tx_out, 1);
    check_eq("idle_tx_busy", a_tx_busy, 0);
    check_eq("no_tx3", tx_done_cnt, 2);
    check_eq("no_rx3", rx_done_cnt, 2);
    check_eq("no_err_loop", rx_err_cnt, 0);

    // Framing error: stop bit low at its centre, then back high.
    line_sel = 1'b1;
    repeat (200) @(negedge clk);
    d0 = rx_done_cnt;
    e0 = rx_err_cnt;
    drive_bad_frame(8'h55, 700);
    repeat (2000) @(negedge clk);
    check_eq("ferr_err_pulse", rx_err_cnt - e0, 1);
    check_eq("ferr_no_done", rx_done_cnt - d0, 0);
    check_eq("ferr_rx_out_kept", b_rx_out, 8'hB1);

    // Glitch shorter than half a bit.
    b0 = busy_cnt;
    tb_line = 1'b0;
    repeat (300) @(negedge clk);
    tb_line = 1'b1;
    repeat (2000) @(negedge clk);
    check_eq("glitch_no_busy", busy_cnt - b0, 0);
    check_eq("glitch_no_done", rx_done_cnt - d0, 0);
    check_eq("glitch_no_err", rx_err_cnt - e0, 1);

    // tx_en abort during the start bit.
    line_sel   = 1'b0;
    td0        = tx_done_cnt;
    d0         = rx_done_cnt;
    e0         = rx_err_cnt;
    a_tx_in    = 8'hC3;
    a_tx_start = 1'b1;
    repeat (300) @(negedge clk);
    check_eq("abort_pre_low", a_tx_out, 0);
    a_tx_en = 1'b0;
    #1;
    check_eq("abort_tx_out", a_tx_out, 1);
    check_eq("abort_tx_busy", a_tx_busy, 0);
    repeat (3000) @(negedge clk);
    check_eq("abort_no_txdone", tx_done_cnt - td0, 0);
    check_eq("abort_no_rxdone", rx_done_cnt - d0, 0);
    check_eq("abort_no_rxerr", rx_err_cnt - e0, 0);

    // Reset in the middle of a frame.
    a_tx_en = 1'b1;
    repeat (600) @(negedge clk);
    check_eq("rstmid_pre_busy", a_tx_busy, 1);
    rst = 1'b1;
    #1;
    check_eq("rstmid_tx_out", a_tx_out, 1);
    check_eq("rstmid_tx_busy", a_tx_busy, 0);
    check_eq("rstmid_rx_out", b_rx_out, 0);
    check_eq("rstmid_rx_busy", b_rx_busy, 0);
    repeat (5) @(negedge clk);
    a_tx_start = 1'b0;
    rst        = 1'b0;
    repeat (3000) @(negedge clk);
    check_eq("rstmid_no_rxdone", rx_done_cnt - d0, 0);
    check_eq("rstmid_idle_out", a_tx_out, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
